apb_master_arbiter: RTL and testbench

- Two-requester arbiter and APB protocol sequencer that drives the peripheral bus slave port (UART, GPIO, SPI, timer, event unit, I2C, FLL, SoC ctrl, debug, kuznechik).
- Requester 0 is the core data bridge; requester 1 is the debug/DMA path.
- Grants are round-robin. The block generates APB SETUP/ACCESS phases, absorbs PREADY wait states and aborts hung transfers with a timeout.
- Returns read data and errors to the granted requester.

---
 rtl/apb_master_arbiter.sv | 127 ++++++++++++
 tb/tb_apb_master_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: two-requester round-robin arbiter driving a single APB master port,
// with wait-state absorption and an ACCESS-phase timeout. rev 1.0
`default_nettype none

module apb_master_arbiter #(
   parameter int          APB_ADDR_WIDTH = 32,
   parameter int          APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [1:0]                    req_i,
   input  logic [1:0]                    we_i,
   input  logic [2*APB_ADDR_WIDTH-1:0]   addr_i,
   input  logic [2*APB_DATA_WIDTH-1:0]   wdata_i,
   output logic [1:0]                    gnt_o,
   output logic [1:0]                    rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]     rdata_o,
   output logic                          err_o,
   output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
   output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
   output logic                          pwrite_o,
   output logic                          psel_o,
   output logic                          penable_o,
   input  logic [APB_DATA_WIDTH-1:0]     prdata_i,
   input  logic                          pready_i,
   input  logic                          pslverr_i
);

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t      state;
   logic        rr_ptr;
   logic        owner;
   logic [15:0] wait_cnt;

   logic                      winner;
   logic                      grant_now;
   logic                      timeout_hit;
   logic [APB_ADDR_WIDTH-1:0] sel_addr;
   logic [APB_DATA_WIDTH-1:0] sel_wdata;
   logic                      sel_we;

   always_comb begin
      winner = 1'b0;
      if (req_i[0] && req_i[1]) begin
         winner = rr_ptr;
      end else if (req_i[1]) begin
         winner = 1'b1;
      end
   end

   assign sel_addr  = winner ? addr_i[2*APB_ADDR_WIDTH-1:APB_ADDR_WIDTH] : addr_i[APB_ADDR_WIDTH-1:0];
   assign sel_wdata = winner ? wdata_i[2*APB_DATA_WIDTH-1:APB_DATA_WIDTH] : wdata_i[APB_DATA_WIDTH-1:0];
   assign sel_we    = winner ? we_i[1] : we_i[0];

   // Grant is combinational; gating with rst_ni keeps it low while reset is held.
   assign grant_now = (state == IDLE) && rst_ni && (|req_i);
   assign gnt_o     = grant_now ? {winner, ~winner} : 2'b00;

   // Abort on the cycle that would make the stall count reach the limit.
   assign timeout_hit = (TIMEOUT_LIMIT != 16'd0) && (wait_cnt == TIMEOUT_LIMIT - 16'd1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         wait_cnt  <= 16'd0;
         rvalid_o  <= 2'b00;
         rdata_o   <= '0;
         err_o     <= 1'b0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         pwrite_o  <= 1'b0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
      end else begin
         rvalid_o <= 2'b00;
         case (state)
            IDLE: begin
               if (|req_i) begin
                  owner    <= winner;
                  paddr_o  <= sel_addr;
                  pwdata_o <= sel_wdata;
                  pwrite_o <= sel_we;
                  psel_o   <= 1'b1;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               penable_o <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (pready_i || timeout_hit) begin
                  psel_o    <= 1'b0;
                  penable_o <= 1'b0;
                  rvalid_o  <= {owner, ~owner};
                  rr_ptr    <= ~owner;
                  wait_cnt  <= 16'd0;
                  state     <= IDLE;
                  if (pready_i) begin
                     rdata_o <= pwrite_o ? '0 : prdata_i;
                     err_o   <= pslverr_i;
                  end else begin
                     rdata_o <= '0;
                     err_o   <= 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed self-checking bench for apb_master_arbiter (TIMEOUT_CYCLES=4).
`default_nettype none

module tb_apb_master_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [63:0] addr;
   logic [63:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   int n_tests = 0;
   int n_fail  = 0;

   apb_master_arbiter #(
      .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req),
      .we_i      (we),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .gnt_o     (gnt),
      .rvalid_o  (rvalid),
      .rdata_o   (rdata),
      .err_o     (err),
      .paddr_o   (paddr),
      .pwdata_o  (pwdata),
      .pwrite_o  (pwrite),
      .psel_o    (psel),
      .penable_o (penable),
      .prdata_i  (prdata),
      .pready_i  (pready),
      .pslverr_i (pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven 1 time unit after the rising edge, checks 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_psel",    {31'd0, psel},    32'd0);
      chk("rst_penable", {31'd0, penable}, 32'd0);
      chk("rst_rvalid",  {30'd0, rvalid},  32'd0);
      chk("rst_gnt",     {30'd0, gnt},     32'd0);
      chk("rst_rdata",   rdata,            32'd0);
      chk("rst_paddr",   paddr,            32'd0);
      tick(); tick();
      #1 rst_n = 1'b1;

      // Single read, zero wait states
      tick();
      req = 2'b01; we = 2'b00; addr[31:0] = 32'h1A10_0000;
      prdata = 32'h1234_5678; pready = 1'b1;
      #1;
      chk("rd_gnt_c0",  {30'd0, gnt}, 32'h1);
      chk("rd_psel_c0", {31'd0, psel}, 32'd0);
      tick(); req = 2'b00; #1;
      chk("rd_psel_c1",    {31'd0, psel},    32'd1);
      chk("rd_penable_c1", {31'd0, penable}, 32'd0);
      chk("rd_paddr_c1",   paddr,            32'h1A10_0000);
      chk("rd_pwrite_c1",  {31'd0, pwrite},  32'd0);
      tick(); #1;
      chk("rd_psel_c2",    {31'd0, psel},    32'd1);
      chk("rd_penable_c2", {31'd0, penable}, 32'd1);
      tick(); #1;
      chk("rd_rvalid_c3",  {30'd0, rvalid},  32'h1);
      chk("rd_rdata_c3",   rdata,            32'h1234_5678);
      chk("rd_err_c3",     {31'd0, err},     32'd0);
      chk("rd_psel_c3",    {31'd0, psel},    32'd0);
      tick(); #1;
      chk("rd_rvalid_c4",  {30'd0, rvalid},  32'd0);
      chk("rd_rdata_hold", rdata,            32'h1234_5678);

      // Write from requester 1 with 3 wait states
      req = 2'b10; we = 2'b10; addr[63:32] = 32'h1A10_1000; wdata[63:32] = 32'hCAFE_F00D;
      pready = 1'b0; prdata = 32'h7777_7777;
      #1;
      chk("wr_gnt", {30'd0, gnt}, 32'h2);
      tick(); req = 2'b00; #1;
      chk("wr_setup_pwdata", pwdata,           32'hCAFE_F00D);
      chk("wr_setup_paddr",  paddr,            32'h1A10_1000);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) pready = 1'b1;
         #1;
         chk("wr_acc_penable", {31'd0, penable}, 32'd1);
         chk("wr_acc_pwdata",  pwdata,           32'hCAFE_F00D);
         chk("wr_acc_pwrite",  {31'd0, pwrite},  32'd1);
         chk("wr_acc_rvalid",  {30'd0, rvalid},  32'd0);
      end
      tick(); #1;
      chk("wr_rvalid", {30'd0, rvalid}, 32'h2);
      chk("wr_rdata",  rdata,           32'd0);
      chk("wr_err",    {31'd0, err},    32'd0);

      // Contention: both requesters held, grants must alternate 0,1,0,1
      req = 2'b11; we = 2'b00; addr[31:0] = 32'h1A10_2000; addr[63:32] = 32'h1A10_3000;
      prdata = 32'h55AA_55AA; pready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk("ct_gnt", {30'd0, gnt}, (k % 2 == 0) ? 32'h1 : 32'h2);
         if (k > 0) chk("ct_rvalid", {30'd0, rvalid}, (k % 2 == 0) ? 32'h2 : 32'h1);
         tick();
         if (k == 3) req = 2'b00;
         #1;
         chk("ct_paddr", paddr, (k % 2 == 0) ? 32'h1A10_2000 : 32'h1A10_3000);
         chk("ct_gnt_busy", {30'd0, gnt}, 32'd0);
         tick(); tick(); #1;
      end
      chk("ct_last_rvalid", {30'd0, rvalid}, 32'h2);
      chk("ct_last_gnt",    {30'd0, gnt},    32'd0);

      // Slave error on a read
      tick();
      req = 2'b01; addr[31:0] = 32'h1A10_4000; prdata = 32'hDEAD_BEEF; pslverr = 1'b1; pready = 1'b1;
      #1;
      chk("se_gnt", {30'd0, gnt}, 32'h1);
      tick(); req = 2'b00; tick(); tick(); #1;
      chk("se_rvalid", {30'd0, rvalid}, 32'h1);
      chk("se_err",    {31'd0, err},    32'd1);
      chk("se_rdata",  rdata,           32'hDEAD_BEEF);
      pslverr = 1'b0;

      // Timeout: pready held low, limit of 4 ACCESS cycles
      tick();
      req = 2'b10; we = 2'b00; addr[63:32] = 32'h1A10_5000; pready = 1'b0;
      #1;
      chk("to_gnt", {30'd0, gnt}, 32'h2);
      tick(); req = 2'b00;
      for (int i = 0; i < 4; i++) begin
         tick(); #1;
         chk("to_acc_psel",    {31'd0, psel},    32'd1);
         chk("to_acc_penable", {31'd0, penable}, 32'd1);
         chk("to_acc_rvalid",  {30'd0, rvalid},  32'd0);
      end
      tick(); #1;
      chk("to_psel_drop", {31'd0, psel},   32'd0);
      chk("to_rvalid",    {30'd0, rvalid}, 32'h2);
      chk("to_err",       {31'd0, err},    32'd1);
      chk("to_rdata",     rdata,           32'd0);

      // Follow-up request completes normally
      req = 2'b01; addr[31:0] = 32'h1A10_6000; prdata = 32'h0BAD_F00D; pready = 1'b1;
      #1;
      chk("fu_gnt", {30'd0, gnt}, 32'h1);
      tick(); req = 2'b00; tick(); tick(); #1;
      chk("fu_rvalid", {30'd0, rvalid}, 32'h1);
      chk("fu_err",    {31'd0, err},    32'd0);
      chk("fu_rdata",  rdata,           32'h0BAD_F00D);

      // Reset in the middle of an ACCESS phase
      tick();
      req = 2'b10; addr[63:32] = 32'h1A10_7000; pready = 1'b0;
      #1;
      chk("mr_gnt", {30'd0, gnt}, 32'h2);
      tick(); tick(); #1;
      chk("mr_penable_pre", {31'd0, penable}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_psel",    {31'd0, psel},    32'd0);
      chk("mr_penable", {31'd0, penable}, 32'd0);
      chk("mr_gnt_rst", {30'd0, gnt},     32'd0);
      chk("mr_rvalid",  {30'd0, rvalid},  32'd0);
      req = 2'b00;
      tick(); #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("mr_no_rvalid", {30'd0, rvalid}, 32'd0);
         chk("mr_no_psel",   {31'd0, psel},   32'd0);
      end
      req = 2'b11; pready = 1'b1;
      #1;
      chk("mr_first_gnt", {30'd0, gnt}, 32'h1);
      tick(); req = 2'b00; tick(); tick(); #1;
      chk("mr_first_rvalid", {30'd0, rvalid}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
